// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed 4-digit hex display scanner with a
// frame-synchronous value update path and optional leading-zero blanking.
module display_scanner #(
    parameter int unsigned DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic        load,
    input  logic        lz_en,
    output logic [3:0]  nibble_out,
    output logic [3:0]  digit_en,
    output logic        frame_tick,
    output logic        pending
);

    localparam int unsigned  PW   = $clog2(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_idx;
    logic [15:0]   r_shadow;
    logic [15:0]   r_active;
    logic          r_pending;
    logic          r_frame_tick;

    logic          w_tick;
    logic          w_frame_end;
    logic          w_commit;
    logic          w_blank;
    logic [3:0]    w_onehot;

    // True when every nibble from position i up to digit 3 is zero.
    // Digit 0 is never reported as blankable so a zero value still shows "0".
    function automatic logic upper_zero(input logic [15:0] v, input logic [1:0] i);
        logic z;
        case (i)
            2'd1:    z = (v[15:4]  == 12'h000);
            2'd2:    z = (v[15:8]  == 8'h00);
            2'd3:    z = (v[15:12] == 4'h0);
            default: z = 1'b0;
        endcase
        return z;
    endfunction

    assign w_tick      = (r_presc == LAST);
    assign w_frame_end = w_tick & (r_idx == 2'd3);
    assign w_commit    = w_frame_end & r_pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
        end else begin
            r_idx <= r_idx;
        end
    end

    // A load coinciding with a commit still lands in the shadow: the active
    // value takes the old shadow and pending stays set for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow  <= 16'h0000;
            r_active  <= 16'h0000;
            r_pending <= 1'b0;
        end else begin
            if (w_commit) begin
                r_active <= r_shadow;
            end else begin
                r_active <= r_active;
            end
            if (load) begin
                r_shadow  <= value_in;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_shadow  <= r_shadow;
                r_pending <= 1'b0;
            end else begin
                r_shadow  <= r_shadow;
                r_pending <= r_pending;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame_end;
        end
    end

    always_comb begin
        nibble_out = 4'h0;
        w_onehot   = 4'b0001;
        case (r_idx)
            2'd0: begin
                nibble_out = r_active[3:0];
                w_onehot   = 4'b0001;
            end
            2'd1: begin
                nibble_out = r_active[7:4];
                w_onehot   = 4'b0010;
            end
            2'd2: begin
                nibble_out = r_active[11:8];
                w_onehot   = 4'b0100;
            end
            2'd3: begin
                nibble_out = r_active[15:12];
                w_onehot   = 4'b1000;
            end
            default: begin
                nibble_out = 4'h0;
                w_onehot   = 4'b0001;
            end
        endcase
    end

    // lz_en is deliberately unregistered so blanking follows it immediately.
    always_comb begin
        w_blank  = lz_en & upper_zero(r_active, r_idx);
        digit_en = 4'b0000;
        if (w_blank) begin
            digit_en = 4'b0000;
        end else begin
            digit_en = w_onehot;
        end
    end

    assign frame_tick = r_frame_tick;
    assign pending    = r_pending;

endmodule

// File: tb/tb_display_scanner.sv
// Directed, table-driven bench for display_scanner with DIV=4 (16-cycle frames).
module tb_display_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  nibble_out;
    logic [3:0]  digit_en;
    logic        frame_tick;
    logic        pending;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [15:0] exp_en;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] shown;

    always #5 clk = ~clk;

    display_scanner #(.DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .lz_en      (lz_en),
        .nibble_out (nibble_out),
        .digit_en   (digit_en),
        .frame_tick (frame_tick),
        .pending    (pending)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
        cyc += n;
    endtask

    // Called at a frame start; checks all 16 samples of one frame.
    task automatic check_frame(input string nm, input logic [15:0] exp_nib,
                               input logic [15:0] exp_en, input logic exp_pend);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] nib_e;
                logic [3:0] en_e;
                logic       ft_e;
                nib_e = exp_nib[4*d +: 4];
                en_e  = exp_en[4*d +: 4];
                ft_e  = (d == 0) && (c == 0) && (cyc > 0);
                chk($sformatf("%s nibble d%0d c%0d", nm, d, c), 16'(nibble_out), 16'(nib_e));
                chk($sformatf("%s digit_en d%0d c%0d", nm, d, c), 16'(digit_en), 16'(en_e));
                chk($sformatf("%s frame_tick d%0d c%0d", nm, d, c), 16'(frame_tick), 16'(ft_e));
                chk($sformatf("%s pending d%0d c%0d", nm, d, c), 16'(pending), 16'(exp_pend));
                tick_n(1);
            end
        end
    endtask

    initial begin
        vecs[0] = '{value: 16'h12AF, lz: 1'b0, exp_en: 16'h8421};
        vecs[1] = '{value: 16'h0050, lz: 1'b1, exp_en: 16'h0021};
        vecs[2] = '{value: 16'h0000, lz: 1'b1, exp_en: 16'h0001};
        vecs[3] = '{value: 16'h0A00, lz: 1'b1, exp_en: 16'h0421};
        vecs[4] = '{value: 16'hF000, lz: 1'b1, exp_en: 16'h8421};
        vecs[5] = '{value: 16'h0050, lz: 1'b0, exp_en: 16'h8421};
        vecs[6] = '{value: 16'h0007, lz: 1'b0, exp_en: 16'h8421};

        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0000;
        lz_en    = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset nibble", 16'(nibble_out), 16'h0000);
        chk("reset digit_en", 16'(digit_en), 16'h0001);
        chk("reset frame_tick", 16'(frame_tick), 16'h0000);
        chk("reset pending", 16'(pending), 16'h0000);

        rst = 1'b0;
        cyc = 0;
        check_frame("scan0", 16'h0000, 16'h8421, 1'b0);
        check_frame("scan1", 16'h0000, 16'h8421, 1'b0);

        shown = 16'h0000;
        for (int i = 0; i < 7; i++) begin
            lz_en = vecs[i].lz;
            tick_n(5);
            load     = 1'b1;
            value_in = vecs[i].value;
            tick_n(1);
            load = 1'b0;
            chk($sformatf("vec%0d pending after load", i), 16'(pending), 16'h0001);
            chk($sformatf("vec%0d old nibble d1", i), 16'(nibble_out), 16'(shown[7:4]));
            tick_n(9);
            chk($sformatf("vec%0d old nibble d3", i), 16'(nibble_out), 16'(shown[15:12]));
            chk($sformatf("vec%0d pending before commit", i), 16'(pending), 16'h0001);
            tick_n(1);
            check_frame($sformatf("vec%0d", i), vecs[i].value, vecs[i].exp_en, 1'b0);
            shown = vecs[i].value;
        end

        // Two loads in one frame: latest wins.
        lz_en = 1'b0;
        tick_n(3);
        load = 1'b1; value_in = 16'h1111;
        tick_n(1);
        load = 1'b0;
        tick_n(4);
        load = 1'b1; value_in = 16'h2222;
        tick_n(1);
        load = 1'b0;
        tick_n(7);
        check_frame("double load", 16'h2222, 16'h8421, 1'b0);

        // Load zero, then toggle lz_en inside the digit-2 slot.
        tick_n(5);
        load = 1'b1; value_in = 16'h0000;
        tick_n(1);
        load = 1'b0;
        tick_n(10);
        tick_n(8);
        lz_en = 1'b1;
        #1;
        chk("lz toggle on d2", 16'(digit_en), 16'h0000);
        lz_en = 1'b0;
        #1;
        chk("lz toggle off d2", 16'(digit_en), 16'h0004);
        tick_n(8);

        // Load on the exact commit edge with 4444 already pending.
        tick_n(5);
        load = 1'b1; value_in = 16'h4444;
        tick_n(1);
        load = 1'b0;
        tick_n(9);
        load = 1'b1; value_in = 16'h3333;
        tick_n(1);
        load = 1'b0;
        check_frame("coincide old", 16'h4444, 16'h8421, 1'b1);
        check_frame("coincide new", 16'h3333, 16'h8421, 1'b0);

        // Reset mid-frame (digit 2) with a pending value.
        tick_n(2);
        load = 1'b1; value_in = 16'h5A5A;
        tick_n(1);
        load = 1'b0;
        tick_n(6);
        chk("pre-reset nibble d2", 16'(nibble_out), 16'h0003);
        chk("pre-reset pending", 16'(pending), 16'h0001);
        rst = 1'b1;
        #1;
        chk("mid reset nibble", 16'(nibble_out), 16'h0000);
        chk("mid reset digit_en", 16'(digit_en), 16'h0001);
        chk("mid reset pending", 16'(pending), 16'h0000);
        chk("mid reset frame_tick", 16'(frame_tick), 16'h0000);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        check_frame("post reset 0", 16'h0000, 16'h8421, 1'b0);
        check_frame("post reset 1", 16'h0000, 16'h8421, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
DISPLAY_SCANNER -- requirements
Module: display_scanner

Interface
REQ-001 The block SHALL have one parameter: DIV, default 50000, clock cycles each digit is held active; legal range 2..2^20.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port value_in, input, 16 bits: four hex digits; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
REQ-005 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures value_in.
REQ-006 The block SHALL have port lz_en, input, 1 bit: enables leading-zero blanking.
REQ-007 The block SHALL have port nibble_out, output, 4 bits: current digit value, fed to the 7-segment decoder data_in.
REQ-008 The block SHALL have port digit_en, output, 4 bits: one-hot, active-high digit select; all-zero means the digit is blanked.
REQ-009 The block SHALL have port frame_tick, output, 1 bit: one-cycle pulse at the end of each 4-digit frame.
REQ-010 The block SHALL have port pending, output, 1 bit: a loaded value is waiting to be committed.

Function
REQ-011 Prescaler SHALL count 0..DIV-1, wrap to 0, and assert internal tick in the cycle where count==DIV-1.
REQ-012 Digit index idx (2 bits) SHALL advance by 1 on every tick, wrapping from 3 to 0.
REQ-013 load SHALL copy value_in into a shadow register on the same edge and set pending=1; a later load before commit overwrites the shadow (latest wins).
REQ-014 Commit SHALL occur on the edge where tick=1 and idx==3 and pending=1: active <= shadow, pending <= 0.
REQ-015 If load and commit coincide, active SHALL take the old shadow, shadow SHALL take the new value_in, and pending SHALL stay 1.
REQ-016 frame_tick SHALL be registered and high for exactly the one cycle following each edge where tick=1 and idx==3, regardless of pending.
REQ-017 nibble_out SHALL equal active[4*idx+3 : 4*idx], combinationally from registered idx and active.
REQ-018 digit_en SHALL be one-hot at bit idx, except that when lz_en=1 and idx>0 and active nibbles idx..3 are all zero it SHALL be 4'b0000.
REQ-019 Digit 0 SHALL never be blanked, so value 0 displays as a single "0".
REQ-020 A change of the displayed value SHALL only take effect at a frame boundary; no frame SHALL show a mix of old and new digits.
REQ-021 lz_en SHALL take effect immediately with no registering.
REQ-022 Each digit SHALL be held for exactly DIV cycles, and a frame SHALL last exactly 4*DIV cycles.

Reset
REQ-023 While rst=1: prescaler=0, idx=0, active=0, shadow=0, pending=0, frame_tick=0; hence nibble_out=4'h0 and digit_en=4'b0001.
REQ-024 Reset asserted mid-frame or with pending=1 SHALL discard the shadow; after release, scanning SHALL restart at digit 0 with a full DIV-cycle hold.

Verification (DIV=4)
REQ-025 Post-reset scan -> digit_en 0001, 0010, 0100, 1000 each for exactly 4 cycles, then repeats; nibble_out=0; frame_tick pulses every 16 cycles.
REQ-026 load with value_in=16'h12AF mid-frame -> pending=1 at once; display stays 0000 until the frame ends; the next frame shows nibbles F, A, 2, 1 on digits 0..3; pending=0.
REQ-027 Two loads in one frame (16'h1111, then 16'h2222) -> the next frame shows 2222 only.
REQ-028 load 16'h3333 on the exact commit edge, with shadow holding 16'h4444 -> the next frame shows 4444 with pending still 1; the following frame shows 3333.
REQ-029 active=16'h0050, lz_en=1 -> digit_en 0001 and 0010 in their slots, 0000 in the slots for digits 2 and 3; with active=0, only digit 0 lights; toggling lz_en=0 restores all enables in the same cycle.
REQ-030 rst pulsed while idx=2 and pending=1 -> outputs immediately return to 4'h0/0001 and pending=0; after release, digit 0 is held 4 cycles.
